// File: rtl/pwm_compare_stage.sv
// PWM compare stage: registered duty compare against an upstream mod-N count.
// New duty values are double-buffered and take effect only at the period boundary.
module pwm_compare_stage #(
    parameter int MOD_VALUE = 8,
    parameter int CW        = $clog2(MOD_VALUE),
    parameter int DW        = $clog2(MOD_VALUE + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [CW-1:0] count_in,
    input  logic [DW-1:0] duty_data,
    input  logic          duty_valid,
    output logic          duty_ready,
    output logic          pwm_out,
    output logic          period_start,
    output logic          load_ack,
    output logic [DW-1:0] active_duty
);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        RUN
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(MOD_VALUE - 1);
    localparam logic [DW-1:0] DMAX = DW'(MOD_VALUE);

    state_t        state;
    state_t        state_nx;
    logic [DW-1:0] shadow;
    logic [DW-1:0] clamped;
    logic          shadow_full;
    logic          accept;
    logic          bnd;
    logic          hit;
    logic          in_run;

    assign in_run     = (state == RUN);
    assign bnd        = (count_in == LAST) && (state == SYNC || in_run);
    assign accept     = duty_valid && !shadow_full;
    assign clamped    = (duty_data > DMAX) ? DMAX : duty_data;
    assign hit        = (DW'(count_in) < active_duty);
    assign duty_ready = ~shadow_full;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (en) state_nx = SYNC;
            SYNC:    if (bnd) state_nx = RUN;
            RUN:     state_nx = RUN;
            default: state_nx = IDLE;
        endcase
        if (!en) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            shadow       <= '0;
            shadow_full  <= 1'b0;
            active_duty  <= '0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
            load_ack     <= 1'b0;
        end else begin
            state        <= state_nx;
            pwm_out      <= en && in_run && hit;
            period_start <= in_run && (count_in == '0);
            load_ack     <= bnd && shadow_full;
            // A write landing on the boundary cycle waits for the next one
            if (bnd && shadow_full) begin
                active_duty <= shadow;
                shadow_full <= 1'b0;
            end
            if (accept) begin
                shadow      <= clamped;
                shadow_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_compare_stage.sv
// Scoreboard bench for pwm_compare_stage: stimulus queues expected loads and
// per-period pwm masks; monitors pop them on load_ack / period_start.
module tb_pwm_compare_stage;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [2:0] count_in = 3'd0;
    logic [3:0] duty_data = 4'd0;
    logic       duty_valid = 1'b0;
    logic       duty_ready;
    logic       pwm_out;
    logic       period_start;
    logic       load_ack;
    logic [3:0] active_duty;

    int n_tests = 0;
    int n_fail = 0;

    logic [3:0] exp_load[$];
    logic [7:0] exp_mask[$];

    pwm_compare_stage #(.MOD_VALUE(8)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .count_in(count_in),
        .duty_data(duty_data),
        .duty_valid(duty_valid),
        .duty_ready(duty_ready),
        .pwm_out(pwm_out),
        .period_start(period_start),
        .load_ack(load_ack),
        .active_duty(active_duty)
    );

    initial forever #5 clk = ~clk;

    // Free-running upstream mod-8 counter
    initial forever begin
        @(posedge clk);
        #1;
        count_in = count_in + 3'd1;
    end

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic to_cnt(input int v);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (count_in != 3'(v) && n < 16);
        if (count_in != 3'(v)) begin
            n_tests++;
            n_fail++;
            $display("FAIL to_cnt timeout: got %0d expected %0d", count_in, v);
        end
    endtask

    task automatic write(input int v);
        duty_data  = 4'(v);
        duty_valid = 1'b1;
        tick();
        duty_valid = 1'b0;
    endtask

    initial begin : load_mon
        forever begin
            @(negedge clk);
            if (load_ack) begin
                if (exp_load.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL load_ack unexpected: active_duty %0d", active_duty);
                end else begin
                    check("load active_duty", active_duty, exp_load.pop_front());
                end
            end
        end
    end

    initial begin : period_mon
        logic [7:0] m;
        forever begin
            @(negedge clk);
            if (period_start) begin
                if (exp_mask.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL period_start unexpected: got 1 expected 0");
                end else begin
                    m = exp_mask.pop_front();
                    check("pwm count0", pwm_out, m[0]);
                    for (int i = 1; i < 8; i++) begin
                        @(negedge clk);
                        check("pwm in period", pwm_out, m[i]);
                        check("period_start mid", period_start, 0);
                    end
                end
            end else begin
                check("pwm outside period", pwm_out, 0);
            end
        end
    end

    initial begin : watchdog
        #200000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : stim
        // Reset state
        tick();
        tick();
        check("rst pwm_out", pwm_out, 0);
        check("rst period_start", period_start, 0);
        check("rst load_ack", load_ack, 0);
        check("rst active_duty", active_duty, 0);
        check("rst duty_ready", duty_ready, 1);
        rst = 1'b0;

        // Test 1: duty 3 written in IDLE, applied at the SYNC boundary
        write(3);
        check("ready after idle write", duty_ready, 0);
        exp_load.push_back(4'd3);
        to_cnt(0);
        en = 1'b1;
        to_cnt(0);
        check("B1 active_duty", active_duty, 3);
        check("B1 duty_ready", duty_ready, 1);
        exp_mask.push_back(8'h07);
        to_cnt(0);
        exp_mask.push_back(8'h07);

        // Test 2: duty 0 then duty 8
        write(0);
        check("ready after write 0", duty_ready, 0);
        exp_load.push_back(4'd0);
        to_cnt(0);
        exp_mask.push_back(8'h00);
        check("B3 duty_ready", duty_ready, 1);
        write(8);
        exp_load.push_back(4'd8);
        to_cnt(0);
        exp_mask.push_back(8'hFF);
        to_cnt(0);
        exp_mask.push_back(8'hFF);

        // Test 3: duty 12 clamps to 8
        write(12);
        exp_load.push_back(4'd8);
        to_cnt(0);
        check("clamp active_duty", active_duty, 8);
        exp_mask.push_back(8'hFF);

        // Test 4: duty 2, then duty 6 written mid-period
        write(2);
        exp_load.push_back(4'd2);
        to_cnt(0);
        exp_mask.push_back(8'h03);
        to_cnt(4);
        write(6);
        exp_load.push_back(4'd6);
        check("ready after mid write", duty_ready, 0);
        to_cnt(7);
        check("ready before bnd", duty_ready, 0);
        to_cnt(0);
        check("ready after bnd", duty_ready, 1);
        exp_mask.push_back(8'h3F);

        // Test 5: write on the boundary cycle defers one period
        to_cnt(7);
        write(5);
        check("bnd write active_duty", active_duty, 6);
        check("bnd write load_ack", load_ack, 0);
        check("bnd write duty_ready", duty_ready, 0);
        exp_mask.push_back(8'h3F);
        exp_load.push_back(4'd5);
        to_cnt(0);
        check("deferred active_duty", active_duty, 5);
        check("deferred load_ack", load_ack, 1);

        // Test 6a: drop en at count 2, re-enable later
        exp_mask.push_back(8'h03);
        to_cnt(2);
        en = 1'b0;
        tick();
        check("en low pwm_out", pwm_out, 0);
        check("en low active_duty", active_duty, 5);
        to_cnt(5);
        en = 1'b1;
        to_cnt(0);
        check("resync pwm_out", pwm_out, 0);
        check("resync active_duty", active_duty, 5);
        exp_mask.push_back(8'h07);

        // Test 6b: reset mid-RUN with a pending duty
        write(1);
        check("pending duty_ready", duty_ready, 0);
        to_cnt(3);
        rst = 1'b1;
        tick();
        check("mid rst pwm_out", pwm_out, 0);
        check("mid rst period_start", period_start, 0);
        check("mid rst load_ack", load_ack, 0);
        check("mid rst active_duty", active_duty, 0);
        check("mid rst duty_ready", duty_ready, 1);
        rst = 1'b0;
        to_cnt(0);
        check("post rst active_duty", active_duty, 0);
        check("post rst load_ack", load_ack, 0);
        exp_mask.push_back(8'h00);
        to_cnt(7);
        en = 1'b0;
        to_cnt(0);
        tick();
        tick();
        tick();

        check("loads left", exp_load.size(), 0);
        check("periods left", exp_mask.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
